// File: rtl/ws2812_rx.sv
// WS2812 single-wire receiver: measures high-pulse widths on the synchronized
// line, rebuilds bytes MSB-first and emits sequential frame-RAM writes.
module ws2812_rx #(
  parameter int unsigned BIT_THRESH   = 10,
  parameter int unsigned MIN_HIGH     = 2,
  parameter int unsigned MAX_HIGH     = 40,
  parameter int unsigned LATCH_CYCLES = 800,
  parameter int unsigned NUM_BYTES    = 216,
  parameter int unsigned ADDR_W       = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_done,
  output logic [ADDR_W-1:0] byte_count,
  output logic              err,
  output logic              overflow
);

  // Pulse/gap counters only ever need to reach LATCH_CYCLES.
  localparam int unsigned CW = $clog2(LATCH_CYCLES + 1);

  localparam logic [CW-1:0]     ONE      = CW'(1);
  localparam logic [CW-1:0]     HMIN     = CW'(MIN_HIGH);
  localparam logic [CW-1:0]     HBIT     = CW'(BIT_THRESH);
  localparam logic [CW-1:0]     HMAX_M1  = CW'(MAX_HIGH - 1);
  localparam logic [CW-1:0]     LATCH_M1 = CW'(LATCH_CYCLES - 1);
  localparam logic [ADDR_W-1:0] NB       = ADDR_W'(NUM_BYTES);
  localparam logic [ADDR_W-1:0] A_ONE    = ADDR_W'(1);

  typedef enum logic [1:0] {S_SYNC, S_IDLE, S_HIGH, S_LOW} state_t;

  logic [1:0]        sync_reg;
  logic              din_s;
  state_t            state_reg, state_next;
  logic [CW-1:0]     hcnt_reg, hcnt_next;
  logic [CW-1:0]     lcnt_reg, lcnt_next;
  logic [2:0]        bitcnt_reg, bitcnt_next;
  logic [7:0]        sreg_reg, sreg_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              wr_en_reg, wr_en_next;
  logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
  logic [7:0]        wr_data_reg, wr_data_next;
  logic              frame_done_reg, frame_done_next;
  logic [ADDR_W-1:0] byte_count_reg, byte_count_next;
  logic              err_reg, err_next;
  logic              overflow_reg, overflow_next;
  logic              bit_val;
  logic [7:0]        shifted;

  // Two-flop synchronizer for the asynchronous strip line.
  always_ff @(posedge clk) begin
    if (rst) sync_reg <= 2'b00;
    else     sync_reg <= {sync_reg[0], din};
  end
  assign din_s = sync_reg[1];

  // State and datapath registers; every output is registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_SYNC;
      hcnt_reg       <= '0;
      lcnt_reg       <= '0;
      bitcnt_reg     <= '0;
      sreg_reg       <= '0;
      addr_reg       <= '0;
      wr_en_reg      <= 1'b0;
      wr_addr_reg    <= '0;
      wr_data_reg    <= '0;
      frame_done_reg <= 1'b0;
      byte_count_reg <= '0;
      err_reg        <= 1'b0;
      overflow_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      hcnt_reg       <= hcnt_next;
      lcnt_reg       <= lcnt_next;
      bitcnt_reg     <= bitcnt_next;
      sreg_reg       <= sreg_next;
      addr_reg       <= addr_next;
      wr_en_reg      <= wr_en_next;
      wr_addr_reg    <= wr_addr_next;
      wr_data_reg    <= wr_data_next;
      frame_done_reg <= frame_done_next;
      byte_count_reg <= byte_count_next;
      err_reg        <= err_next;
      overflow_reg   <= overflow_next;
    end
  end

  // Next-state logic: pulse measurement, bit decode, byte write and frame end.
  always_comb begin
    state_next      = state_reg;
    hcnt_next       = hcnt_reg;
    lcnt_next       = lcnt_reg;
    bitcnt_next     = bitcnt_reg;
    sreg_next       = sreg_reg;
    addr_next       = addr_reg;
    wr_en_next      = 1'b0;
    wr_addr_next    = wr_addr_reg;
    wr_data_next    = wr_data_reg;
    frame_done_next = 1'b0;
    byte_count_next = byte_count_reg;
    err_next        = 1'b0;
    overflow_next   = overflow_reg;
    bit_val         = (hcnt_reg >= HBIT);
    shifted         = {sreg_reg[6:0], bit_val};

    unique case (state_reg)
      S_SYNC: begin
        // Resynchronizing: hold the frame position cleared, wait for a full latch gap.
        addr_next   = '0;
        bitcnt_next = '0;
        if (din_s) begin
          lcnt_next = '0;
        end else if (lcnt_reg >= LATCH_M1) begin
          lcnt_next  = '0;
          state_next = S_IDLE;
        end else begin
          lcnt_next = lcnt_reg + ONE;
        end
      end
      S_IDLE: begin
        if (din_s) begin
          state_next = S_HIGH;
          hcnt_next  = ONE;
        end
      end
      S_HIGH: begin
        if (din_s) begin
          if (hcnt_reg < HMAX_M1) begin
            hcnt_next = hcnt_reg + ONE;
          end else begin
            // Line stuck high: abandon the frame and wait for a clean gap.
            err_next   = 1'b1;
            lcnt_next  = '0;
            state_next = S_SYNC;
          end
        end else if (hcnt_reg < HMIN) begin
          // Glitch: too short to be a real bit.
          err_next   = 1'b1;
          lcnt_next  = '0;
          state_next = S_SYNC;
        end else begin
          sreg_next   = shifted;
          bitcnt_next = bitcnt_reg + 3'd1;
          lcnt_next   = ONE;
          state_next  = S_LOW;
          if (bitcnt_reg == 3'd7) begin
            if (addr_reg < NB) begin
              wr_en_next   = 1'b1;
              wr_data_next = shifted;
              wr_addr_next = addr_reg;
              addr_next    = addr_reg + A_ONE;
              // First byte of a new frame clears the previous frame's overflow.
              if (addr_reg == '0) overflow_next = 1'b0;
            end else begin
              overflow_next = 1'b1;
            end
          end
        end
      end
      S_LOW: begin
        if (din_s) begin
          state_next = S_HIGH;
          hcnt_next  = ONE;
        end else if (lcnt_reg >= LATCH_M1) begin
          // Latch gap: close the frame; a partial byte is discarded and flagged.
          frame_done_next = 1'b1;
          byte_count_next = addr_reg;
          err_next        = (bitcnt_reg != 3'd0);
          addr_next       = '0;
          bitcnt_next     = '0;
          lcnt_next       = '0;
          state_next      = S_IDLE;
        end else begin
          lcnt_next = lcnt_reg + ONE;
        end
      end
      default: state_next = S_SYNC;
    endcase
  end

  assign wr_en      = wr_en_reg;
  assign wr_addr    = wr_addr_reg;
  assign wr_data    = wr_data_reg;
  assign frame_done = frame_done_reg;
  assign byte_count = byte_count_reg;
  assign err        = err_reg;
  assign overflow   = overflow_reg;

endmodule
